// File: rtl/lfsr_pkg.sv
// Shared definitions for the ranged LFSR random number generator:
// maximal-length tap masks, default seed and sampler state encoding.
package lfsr_pkg;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

    typedef enum logic {
        ST_IDLE,
        ST_SAMPLE
    } rng_state_e;

    // Bit (t-1) set for each tap t of a primitive polynomial of degree w.
    function automatic logic [31:0] tap_mask(input int unsigned w);
        logic [31:0] m;
        m = '0;
        case (w)
            4:  m = 32'h0000_000C;
            5:  m = 32'h0000_0014;
            6:  m = 32'h0000_0030;
            7:  m = 32'h0000_0060;
            8:  m = 32'h0000_00B8;
            9:  m = 32'h0000_0110;
            10: m = 32'h0000_0240;
            11: m = 32'h0000_0500;
            12: m = 32'h0000_0829;
            13: m = 32'h0000_100D;
            14: m = 32'h0000_2015;
            15: m = 32'h0000_6000;
            16: m = 32'h0000_B400;
            17: m = 32'h0001_2000;
            18: m = 32'h0002_0400;
            19: m = 32'h0004_0023;
            20: m = 32'h0009_0000;
            21: m = 32'h0014_0000;
            22: m = 32'h0030_0000;
            23: m = 32'h0042_0000;
            24: m = 32'h00E1_0000;
            25: m = 32'h0120_0000;
            26: m = 32'h0200_0023;
            27: m = 32'h0400_0013;
            28: m = 32'h0900_0000;
            29: m = 32'h1400_0000;
            30: m = 32'h2000_0029;
            31: m = 32'h4800_0000;
            32: m = 32'h8020_0003;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR (shift-left, feedback into bit 0) with seed load
// and automatic recovery from the all-zero lock-up state.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    assign w_fb  = ^(r_state & TAPS);
    assign state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (load_val == '0) ? SEED : load_val;
        end else if (r_state == '0) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[WIDTH-2:0], w_fb};
        end
    end

endmodule

// File: rtl/lfsr_range_rng.sv
// Ranged random sampler: masks the LFSR down to the smallest power-of-two
// window covering the limit and rejects out-of-range draws, with a fallback.
module lfsr_range_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      OUT_W     = 10,
    parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED[WIDTH-1:0],
    parameter int unsigned      MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic [WIDTH-1:0] raw
);

    localparam logic [7:0]       LAST_TRY = 8'(MAX_TRIES - 1);
    localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

    rng_state_e       r_state, w_state_nxt;
    logic [OUT_W-1:0] r_lim, w_lim_nxt;
    logic [7:0]       r_try, w_try_nxt;
    logic [OUT_W-1:0] r_value, w_value_nxt;
    logic             r_valid, w_valid_nxt;

    logic [WIDTH-1:0] w_raw;
    logic [OUT_W-1:0] w_lim_m1;
    logic [OUT_W-1:0] w_mask;
    logic [OUT_W-1:0] w_cand;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (w_raw)
    );

    assign raw   = w_raw;
    assign busy  = (r_state == ST_SAMPLE);
    assign valid = r_valid;
    assign value = r_value;

    // Smear (lim-1) to the right: every bit at or below its MSB becomes 1.
    // lim=1 gives an empty mask so the only draw is 0; lim=0 takes the full range.
    assign w_lim_m1 = r_lim - ONE;
    always_comb begin
        w_mask = '0;
        if (r_lim == '0) begin
            w_mask = '1;
        end else begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
                w_mask[i] = |(w_lim_m1 >> i);
            end
        end
    end

    assign w_cand = w_raw[OUT_W-1:0] & w_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_lim_nxt   = r_lim;
        w_try_nxt   = r_try;
        w_value_nxt = r_value;
        w_valid_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Holding off while valid is high makes a req in the result cycle a no-op.
                if (req && !seed_load && !r_valid) begin
                    w_state_nxt = ST_SAMPLE;
                    w_lim_nxt   = limit;
                    w_try_nxt   = '0;
                end
            end
            ST_SAMPLE: begin
                if (seed_load) begin
                    w_state_nxt = ST_IDLE;
                end else if ((r_lim == '0) || (w_cand < r_lim)) begin
                    w_value_nxt = w_cand;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_try == LAST_TRY) begin
                    w_value_nxt = w_cand - r_lim;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_try_nxt = r_try + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_lim   <= '0;
            r_try   <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lim   <= w_lim_nxt;
            r_try   <= w_try_nxt;
            r_value <= w_value_nxt;
            r_valid <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Randomized bench for lfsr_range_rng against a cycle-level behavioural model.
module tb_lfsr_range_rng;

    localparam int          MAX_TRIES = 8;
    localparam logic [15:0] SEED16    = 16'hACE1;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [9:0]  limit;
    logic        busy;
    logic        valid;
    logic [9:0]  value;
    logic [15:0] raw;

    logic        s8_load;
    logic [7:0]  s8_seed;
    logic        req8;
    logic [3:0]  limit8;
    logic        busy8;
    logic        valid8;
    logic [3:0]  value8;
    logic [7:0]  raw8;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_raw   = '0;
    bit          m_busy  = 0;
    bit          m_valid = 0;
    int          m_value = 0;
    int          m_lim   = 0;
    int          m_tries = 0;

    bit seen [100];

    lfsr_range_rng #(
        .WIDTH     (16),
        .OUT_W     (10),
        .MAX_TRIES (MAX_TRIES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .limit     (limit),
        .busy      (busy),
        .valid     (valid),
        .value     (value),
        .raw       (raw)
    );

    lfsr_range_rng #(
        .WIDTH     (8),
        .OUT_W     (4),
        .SEED      (8'hE1),
        .MAX_TRIES (MAX_TRIES)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .seed_load (s8_load),
        .seed_in   (s8_seed),
        .req       (req8),
        .limit     (limit8),
        .busy      (busy8),
        .valid     (valid8),
        .value     (value8),
        .raw       (raw8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Characteristic polynomial x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        int taps [4] = '{16, 14, 13, 11};
        logic fb;
        fb = 1'b0;
        foreach (taps[k]) fb = fb ^ s[taps[k]-1];
        return {s[14:0], fb};
    endfunction

    // Smallest 2^k-1 window that still contains lim-1.
    function automatic int mask_of(input int lim);
        int m;
        if (lim == 0) return 1023;
        m = 0;
        while (m < lim - 1) m = m * 2 + 1;
        return m;
    endfunction

    task automatic tick();
        logic [15:0] raw_old;
        bit          valid_old;
        int          cand;
        raw_old   = m_raw;
        valid_old = m_valid;
        m_valid   = 0;
        if (rst) begin
            m_raw = SEED16; m_busy = 0; m_value = 0; m_tries = 0; m_lim = 0;
        end else begin
            if (seed_load)          m_raw = (seed_in == 16'h0) ? SEED16 : seed_in;
            else if (raw_old == '0) m_raw = SEED16;
            else                    m_raw = lfsr16_next(raw_old);
            if (m_busy) begin
                if (seed_load) begin
                    m_busy = 0;
                end else begin
                    cand = int'(raw_old[9:0]) & mask_of(m_lim);
                    if (m_lim == 0 || cand < m_lim) begin
                        m_value = cand; m_valid = 1; m_busy = 0;
                    end else begin
                        m_tries++;
                        if (m_tries == MAX_TRIES) begin
                            m_value = cand - m_lim; m_valid = 1; m_busy = 0;
                        end
                    end
                end
            end else if (req && !seed_load && !valid_old) begin
                m_busy = 1; m_lim = int'(limit); m_tries = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("raw",   32'(raw),   32'(m_raw));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("value", 32'(value), 32'(m_value));
    endtask

    // Issue one request and wait for the result; lat counts cycles from req.
    task automatic do_req(input int lim, input bit rnd_lim, output int lat);
        req   = 1'b1;
        limit = 10'(lim);
        tick();
        req = 1'b0;
        lat = 1;
        while (!valid && lat < 20) begin
            if (rnd_lim) limit = 10'($urandom_range(0, 1023));
            tick();
            lat++;
        end
        chk("lat_bound", 32'(lat < 20), 32'd1);
        // A req during the result cycle must be ignored.
        req = 1'($urandom_range(0, 1));
        tick();
        req = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int vcnt;
        int hits;
        int saved;
        bit zero_seen;

        rst = 1'b1; seed_load = 1'b0; seed_in = '0; req = 1'b0; limit = '0;
        s8_load = 1'b0; s8_seed = '0; req8 = 1'b0; limit8 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_raw",   32'(raw),   32'h0000_ACE1);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        tick();
        chk("step1_raw", 32'(raw), 32'h0000_59C3);

        seed_load = 1'b1; seed_in = 16'h0;
        tick();
        seed_load = 1'b0;
        chk("zero_seed", 32'(raw), 32'h0000_ACE1);

        // 8-bit period from seed 1
        s8_load = 1'b1; s8_seed = 8'h01;
        tick();
        s8_load = 1'b0;
        chk("w8_seed", 32'(raw8), 32'h01);
        n = 0;
        zero_seen = 0;
        do begin
            tick();
            n++;
            if (raw8 == 8'h00) zero_seen = 1;
        end while (raw8 != 8'h01 && n < 300);
        chk("w8_period", 32'(n), 32'd255);
        chk("w8_nonzero", 32'(zero_seen), 32'd0);

        for (int i = 0; i < 100; i++) begin
            do_req(1, 0, lat);
            chk("lim1_value", 32'(value), 32'd0);
            chk("lim1_lat", 32'(lat), 32'd2);
        end

        // Random limits, limit wiggled while busy, occasional reseeds
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                seed_load = 1'b1;
                seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                tick();
                seed_load = 1'b0;
            end
            do_req($urandom_range(0, 1023), 1, lat);
            chk("rnd_lat", 32'(lat >= 2 && lat <= 1 + MAX_TRIES), 32'd1);
        end

        for (int i = 0; i < 10000; i++) begin
            do_req(100, 0, lat);
            chk("lim100_range", 32'(value < 10'd100), 32'd1);
            chk("lim100_lat", 32'(lat >= 2 && lat <= 1 + MAX_TRIES), 32'd1);
            if (value < 10'd100) seen[value] = 1;
        end
        hits = 0;
        foreach (seen[k]) hits += int'(seen[k]);
        chk("lim100_cover", 32'(hits), 32'd100);

        // Abort by seed_load one cycle after req
        saved = m_value;
        req = 1'b1; limit = 10'd7;
        tick();
        req = 1'b0; seed_load = 1'b1; seed_in = 16'($urandom);
        tick();
        seed_load = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vcnt += int'(valid);
        end
        chk("abort_novalid", 32'(vcnt), 32'd0);
        chk("abort_value", 32'(value), 32'(saved));

        // req and seed_load on the same idle edge
        req = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
        tick();
        req = 1'b0; seed_load = 1'b0;
        chk("same_edge_busy", 32'(busy), 32'd0);

        // Extra req mid-sample yields exactly one result
        req = 1'b1; limit = 10'd0;
        tick();
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            req = (i == 0) ? 1'b1 : 1'b0;
            tick();
            vcnt += int'(valid);
        end
        chk("mid_req_one", 32'(vcnt), 32'd1);

        // Reset while sampling
        req = 1'b1; limit = 10'd3;
        tick();
        req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_raw", 32'(raw), 32'h0000_ACE1);
        tick();

        chk("w8_valid", 32'(valid8), 32'd0);
        chk("w8_busy", 32'(busy8), 32'd0);
        chk("w8_value", 32'(value8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
